// File: rtl/spi_cs_arbiter.sv
// Round-robin arbiter that shares one single-CS SPI master among NUM_REQ requesters
// and steers the master's chip select onto the granted device's o_SPI_CS_n bit.
//
// state   | meaning
// IDLE    | no grant; arbitrate once a request is pending and the master is ready
// ACTIVE  | requester g_idx owns the master; waits for a complete CS-low burst
// RELEASE | burst complete; waits out the master's CS-inactive time
module spi_cs_arbiter #(
    parameter int NUM_REQ          = 2,
    parameter int MAX_BYTES_PER_CS = 2,
    localparam int CW              = $clog2(MAX_BYTES_PER_CS + 1)
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_L,

    input  logic [NUM_REQ-1:0]    i_Req,
    input  logic [NUM_REQ*CW-1:0] i_Req_TX_Count,
    input  logic [NUM_REQ*8-1:0]  i_Req_TX_Byte,
    input  logic [NUM_REQ-1:0]    i_Req_TX_DV,
    output logic [NUM_REQ-1:0]    o_Req_TX_Ready,
    output logic [NUM_REQ-1:0]    o_Grant,
    output logic [NUM_REQ-1:0]    o_Req_RX_DV,
    output logic [7:0]            o_Req_RX_Byte,
    output logic [NUM_REQ-1:0]    o_Req_Done,

    output logic [CW-1:0]         o_M_TX_Count,
    output logic [7:0]            o_M_TX_Byte,
    output logic                  o_M_TX_DV,
    input  logic                  i_M_TX_Ready,
    input  logic                  i_M_RX_DV,
    input  logic [7:0]            i_M_RX_Byte,
    input  logic                  i_M_CS_n,

    output logic [NUM_REQ-1:0]    o_SPI_CS_n
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t             state;
    logic [IW-1:0]      g_idx;
    logic [IW-1:0]      last_served;
    logic               cs_seen;

    logic               win_found;
    logic [IW-1:0]      win_idx;
    logic [IW:0]        cand;
    logic [NUM_REQ-1:0] win_onehot;

    logic               active;
    logic [CW-1:0]      g_count;
    logic [7:0]         g_byte;

    // Search upward from last_served+1 with wrap, so a just-served requester is last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = {1'b0, last_served} + (IW+1)'(i);
            if (cand >= (IW+1)'(NUM_REQ)) begin
                cand = cand - (IW+1)'(NUM_REQ);
            end
            if (!win_found && i_Req[cand[IW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        win_onehot          = '0;
        win_onehot[win_idx] = 1'b1;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state       <= IDLE;
            o_Grant     <= '0;
            o_Req_Done  <= '0;
            g_idx       <= '0;
            last_served <= IW'(NUM_REQ - 1);
            cs_seen     <= 1'b0;
        end else begin
            o_Req_Done <= '0;
            case (state)
                IDLE: begin
                    cs_seen <= 1'b0;
                    if (win_found && i_M_TX_Ready) begin
                        g_idx   <= win_idx;
                        o_Grant <= win_onehot;
                        state   <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (cs_seen && i_M_CS_n) begin
                        o_Req_Done  <= o_Grant;
                        o_Grant     <= '0;
                        last_served <= g_idx;
                        cs_seen     <= 1'b0;
                        state       <= RELEASE;
                    end else if (!cs_seen && !i_Req[g_idx]) begin
                        // Withdrawn before the burst started: no Done, pointer kept.
                        o_Grant <= '0;
                        state   <= IDLE;
                    end else if (!i_M_CS_n) begin
                        cs_seen <= 1'b1;
                    end
                end
                RELEASE: begin
                    if (i_M_TX_Ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    o_Grant <= '0;
                    cs_seen <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        active  = (state == ACTIVE);
        g_count = i_Req_TX_Count[int'(g_idx)*CW +: CW];
        g_byte  = i_Req_TX_Byte[int'(g_idx)*8 +: 8];
    end

    always_comb begin
        o_M_TX_DV    = active & i_Req_TX_DV[g_idx];
        o_M_TX_Byte  = active ? g_byte : 8'h00;
        o_M_TX_Count = '0;
        if (active) begin
            o_M_TX_Count = (g_count == '0) ? CW'(1) : g_count;
        end
    end

    assign o_Req_TX_Ready = (active && i_M_TX_Ready) ? o_Grant : '0;
    assign o_Req_RX_DV    = i_M_RX_DV ? o_Grant : '0;
    assign o_Req_RX_Byte  = i_M_RX_Byte;
    assign o_SPI_CS_n     = ~o_Grant | {NUM_REQ{i_M_CS_n}};

endmodule

// File: tb/tb_spi_cs_arbiter.sv
// Bench for spi_cs_arbiter: behavioural SPI master, scoreboard queues for master TX,
// requester RX and Done, directed corner sequences and a round-robin vector table.
module tb_spi_cs_arbiter;

    localparam int NUM_REQ = 2;
    localparam int MAX_B   = 2;
    localparam int CW      = $clog2(MAX_B + 1);

    logic                  i_Clk;
    logic                  i_Rst_L;
    logic [NUM_REQ-1:0]    i_Req;
    logic [NUM_REQ*CW-1:0] i_Req_TX_Count;
    logic [NUM_REQ*8-1:0]  i_Req_TX_Byte;
    logic [NUM_REQ-1:0]    i_Req_TX_DV;
    logic [NUM_REQ-1:0]    o_Req_TX_Ready;
    logic [NUM_REQ-1:0]    o_Grant;
    logic [NUM_REQ-1:0]    o_Req_RX_DV;
    logic [7:0]            o_Req_RX_Byte;
    logic [NUM_REQ-1:0]    o_Req_Done;
    logic [CW-1:0]         o_M_TX_Count;
    logic [7:0]            o_M_TX_Byte;
    logic                  o_M_TX_DV;
    logic                  i_M_TX_Ready;
    logic                  i_M_RX_DV;
    logic [7:0]            i_M_RX_Byte;
    logic                  i_M_CS_n;
    logic [NUM_REQ-1:0]    o_SPI_CS_n;

    spi_cs_arbiter #(.NUM_REQ(NUM_REQ), .MAX_BYTES_PER_CS(MAX_B)) dut (
        .i_Clk          (i_Clk),
        .i_Rst_L        (i_Rst_L),
        .i_Req          (i_Req),
        .i_Req_TX_Count (i_Req_TX_Count),
        .i_Req_TX_Byte  (i_Req_TX_Byte),
        .i_Req_TX_DV    (i_Req_TX_DV),
        .o_Req_TX_Ready (o_Req_TX_Ready),
        .o_Grant        (o_Grant),
        .o_Req_RX_DV    (o_Req_RX_DV),
        .o_Req_RX_Byte  (o_Req_RX_Byte),
        .o_Req_Done     (o_Req_Done),
        .o_M_TX_Count   (o_M_TX_Count),
        .o_M_TX_Byte    (o_M_TX_Byte),
        .o_M_TX_DV      (o_M_TX_DV),
        .i_M_TX_Ready   (i_M_TX_Ready),
        .i_M_RX_DV      (i_M_RX_DV),
        .i_M_RX_Byte    (i_M_RX_Byte),
        .i_M_CS_n       (i_M_CS_n),
        .o_SPI_CS_n     (o_SPI_CS_n)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    int errs   = 0;
    int checks = 0;

    typedef struct {
        int         r;
        logic [7:0] b;
    } rx_t;

    logic [7:0] exp_mtx[$];
    rx_t        exp_rx[$];
    int         exp_done[$];

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        errs++;
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    // Behavioural single-CS SPI master: 3-cycle byte time, RX byte = ~TX byte,
    // CS-inactive gap with TX_Ready low before accepting the next burst.
    int         m_state;
    int         m_left;
    int         m_timer;
    logic [7:0] m_cur;
    logic       s_dv;
    logic [7:0] s_byte;
    logic [CW-1:0] s_cnt;

    initial begin : master
        i_M_TX_Ready = 1'b1;
        i_M_CS_n     = 1'b1;
        i_M_RX_DV    = 1'b0;
        i_M_RX_Byte  = 8'h00;
        m_state      = 0;
        m_left       = 0;
        m_timer      = 0;
        m_cur        = 8'h00;
        forever begin
            @(negedge i_Clk);
            s_dv   = o_M_TX_DV;
            s_byte = o_M_TX_Byte;
            s_cnt  = o_M_TX_Count;
            @(posedge i_Clk);
            #1;
            i_M_RX_DV = 1'b0;
            if (!i_Rst_L) begin
                m_state      = 0;
                i_M_TX_Ready = 1'b1;
                i_M_CS_n     = 1'b1;
            end else begin
                case (m_state)
                    0, 2: if (s_dv) begin
                        if (m_state == 0) m_left = int'(s_cnt);
                        if (exp_mtx.size() == 0) fail("m_tx_unexpected", 32'(s_byte), 32'h0);
                        else check_eq("m_tx_byte", 32'(s_byte), 32'(exp_mtx.pop_front()));
                        m_cur        = s_byte;
                        i_M_TX_Ready = 1'b0;
                        i_M_CS_n     = 1'b0;
                        m_timer      = 3;
                        m_state      = 1;
                    end
                    1: begin
                        m_timer--;
                        if (m_timer == 0) begin
                            i_M_RX_DV   = 1'b1;
                            i_M_RX_Byte = ~m_cur;
                            m_left--;
                            if (m_left > 0) begin
                                i_M_TX_Ready = 1'b1;
                                m_state      = 2;
                            end else begin
                                m_state = 3;
                            end
                        end
                    end
                    3: begin
                        i_M_CS_n = 1'b1;
                        m_timer  = 2;
                        m_state  = 4;
                    end
                    4: begin
                        m_timer--;
                        if (m_timer == 0) begin
                            i_M_TX_Ready = 1'b1;
                            m_state      = 0;
                        end
                    end
                    default: m_state = 0;
                endcase
            end
        end
    end

    initial begin : monitor
        rx_t e;
        int  d;
        forever begin
            @(negedge i_Clk);
            if (i_Rst_L) begin
                check_eq("grant_onehot", 32'($countones(o_Grant) <= 1), 32'h1);
                check_eq("cs_nongranted_high", 32'(o_SPI_CS_n | o_Grant), 32'((1 << NUM_REQ) - 1));
                check_eq("ready_nongranted_low", 32'(o_Req_TX_Ready & ~o_Grant), 32'h0);
                if (o_Req_RX_DV != '0) begin
                    if (exp_rx.size() == 0) fail("rx_dv_unexpected", 32'(o_Req_RX_DV), 32'h0);
                    else begin
                        e = exp_rx.pop_front();
                        check_eq("rx_dv", 32'(o_Req_RX_DV), 32'(1 << e.r));
                        check_eq("rx_byte", 32'(o_Req_RX_Byte), 32'(e.b));
                    end
                end
                if (o_Req_Done != '0) begin
                    if (exp_done.size() == 0) fail("done_unexpected", 32'(o_Req_Done), 32'h0);
                    else begin
                        d = exp_done.pop_front();
                        check_eq("done", 32'(o_Req_Done), 32'(1 << d));
                    end
                end
            end
        end
    end

    task automatic wait_grant(output int g);
        bit found;
        g     = -1;
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            @(negedge i_Clk);
            if (o_Grant != '0) begin
                found = 1'b1;
                for (int r = 0; r < NUM_REQ; r++) if (o_Grant[r]) g = r;
            end
        end
        if (!found) fail("grant_timeout", 32'h0, 32'h1);
    endtask

    task automatic send_byte(input int r, input logic [7:0] b);
        bit  rdy;
        rx_t e;
        rdy = 1'b0;
        for (int k = 0; k < 300 && !rdy; k++) begin
            @(negedge i_Clk);
            if (o_Req_TX_Ready[r]) rdy = 1'b1;
        end
        if (!rdy) begin
            fail("tx_ready_timeout", 32'(r), 32'h1);
        end else begin
            tick();
            i_Req_TX_Byte[r*8 +: 8] = b;
            i_Req_TX_DV[r]          = 1'b1;
            exp_mtx.push_back(b);
            e.r = r;
            e.b = ~b;
            exp_rx.push_back(e);
            tick();
            i_Req_TX_DV[r] = 1'b0;
        end
    endtask

    task automatic wait_drain();
        bit empty;
        empty = 1'b0;
        for (int k = 0; k < 400 && !empty; k++) begin
            @(negedge i_Clk);
            empty = (exp_mtx.size() == 0) && (exp_rx.size() == 0) && (exp_done.size() == 0);
        end
        if (!empty) fail("drain_timeout", 32'(exp_rx.size() + exp_done.size()), 32'h0);
    endtask

    task automatic serve(input int r, input int cnt, input logic [7:0] b0, input logic [7:0] b1);
        exp_done.push_back(r);
        send_byte(r, b0);
        if (cnt > 1) send_byte(r, b1);
        wait_drain();
    endtask

    task automatic set_count(input int r, input int cnt);
        i_Req_TX_Count[r*CW +: CW] = CW'(cnt);
    endtask

    task automatic clear_sb();
        exp_mtx.delete();
        exp_rx.delete();
        exp_done.delete();
    endtask

    typedef struct {
        logic [1:0] req;
        int         cnt;
        logic [7:0] b0;
        logic [7:0] b1;
        int         exp_g;
    } vec_t;

    vec_t tbl[6];

    initial begin : stim
        int g;
        tbl[0] = '{2'b11, 1, 8'h01, 8'h02, 0};
        tbl[1] = '{2'b11, 2, 8'h10, 8'h20, 1};
        tbl[2] = '{2'b11, 0, 8'h33, 8'h00, 0};
        tbl[3] = '{2'b11, 2, 8'h44, 8'h55, 1};
        tbl[4] = '{2'b01, 2, 8'h66, 8'h77, 0};
        tbl[5] = '{2'b10, 1, 8'h88, 8'h00, 1};

        i_Rst_L        = 1'b0;
        i_Req          = '1;
        i_Req_TX_DV    = '1;
        i_Req_TX_Count = '0;
        i_Req_TX_Byte  = '1;
        repeat (3) @(posedge i_Clk);
        @(negedge i_Clk);
        check_eq("rst_grant", 32'(o_Grant), 32'h0);
        check_eq("rst_done", 32'(o_Req_Done), 32'h0);
        check_eq("rst_cs_n", 32'(o_SPI_CS_n), 32'h3);
        check_eq("rst_m_tx_dv", 32'(o_M_TX_DV), 32'h0);
        check_eq("rst_tx_ready", 32'(o_Req_TX_Ready), 32'h0);
        check_eq("rst_rx_dv", 32'(o_Req_RX_DV), 32'h0);
        tick();
        i_Req         = '0;
        i_Req_TX_DV   = '0;
        i_Req_TX_Byte = '0;
        tick();
        i_Rst_L = 1'b1;
        tick();

        // Abort before any byte, then the pointer must still favour requester 0.
        set_count(0, 1);
        i_Req = 2'b01;
        @(negedge i_Clk);
        check_eq("abort_grant_lat0", 32'(o_Grant), 32'h0);
        @(negedge i_Clk);
        check_eq("abort_grant", 32'(o_Grant), 32'h1);
        tick();
        i_Req = 2'b00;
        @(negedge i_Clk);
        @(negedge i_Clk);
        check_eq("abort_dropped", 32'(o_Grant), 32'h0);
        tick();
        i_Req = 2'b11;
        wait_grant(g);
        check_eq("abort_ptr_kept", 32'(g), 32'h0);
        if (g >= 0) serve(g, 1, 8'h11, 8'h00);
        tick();
        i_Req = 2'b00;

        // Single request on requester 1, two bytes.
        set_count(1, 2);
        tick();
        i_Req = 2'b10;
        @(negedge i_Clk);
        check_eq("single_grant_lat0", 32'(o_Grant), 32'h0);
        @(negedge i_Clk);
        check_eq("single_grant", 32'(o_Grant), 32'h2);
        check_eq("single_count", 32'(o_M_TX_Count), 32'h2);
        serve(1, 2, 8'hA5, 8'h3C);
        tick();
        i_Req = 2'b00;

        // Zero count is forwarded as one byte.
        set_count(1, 0);
        tick();
        i_Req = 2'b10;
        wait_grant(g);
        check_eq("zero_grant", 32'(g), 32'h1);
        check_eq("zero_count", 32'(o_M_TX_Count), 32'h1);
        if (g >= 0) serve(g, 1, 8'h5A, 8'h00);
        tick();
        i_Req = 2'b00;

        // Non-granted requester pulses TX_DV with 0xFF; master must never see it.
        set_count(0, 2);
        set_count(1, 1);
        tick();
        i_Req = 2'b01;
        wait_grant(g);
        check_eq("ignore_grant", 32'(g), 32'h0);
        tick();
        i_Req_TX_Byte[15:8] = 8'hFF;
        i_Req_TX_DV[1]      = 1'b1;
        tick();
        i_Req_TX_DV[1] = 1'b0;
        serve(0, 2, 8'h12, 8'h34);
        tick();
        i_Req = 2'b00;

        // Reset during byte 1 of a 2-byte burst on requester 1.
        set_count(1, 2);
        tick();
        i_Req = 2'b10;
        wait_grant(g);
        check_eq("rstmid_grant", 32'(g), 32'h1);
        send_byte(1, 8'hC3);
        @(negedge i_Clk);
        #2;
        i_Rst_L = 1'b0;
        #1;
        check_eq("rstmid_async_grant", 32'(o_Grant), 32'h0);
        check_eq("rstmid_async_cs_n", 32'(o_SPI_CS_n), 32'h3);
        clear_sb();
        i_Req = 2'b00;
        tick();
        tick();
        i_Rst_L = 1'b1;
        tick();
        i_Req = 2'b11;
        wait_grant(g);
        check_eq("rstmid_ptr_reset", 32'(g), 32'h0);

        // Fresh reset, then both held: round-robin table.
        tick();
        i_Rst_L = 1'b0;
        i_Req   = 2'b00;
        clear_sb();
        tick();
        tick();
        i_Rst_L = 1'b1;
        for (int v = 0; v < 6; v++) begin
            tick();
            i_Req = tbl[v].req;
            for (int r = 0; r < NUM_REQ; r++) set_count(r, tbl[v].cnt);
            wait_grant(g);
            check_eq("tbl_grant", 32'(o_Grant), 32'(1 << tbl[v].exp_g));
            check_eq("tbl_count", 32'(o_M_TX_Count), 32'((tbl[v].cnt == 0) ? 1 : tbl[v].cnt));
            if (g >= 0) serve(g, tbl[v].cnt, tbl[v].b0, tbl[v].b1);
        end
        tick();
        i_Req = 2'b00;
        repeat (10) tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        fail("global_timeout", 32'h0, 32'h1);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
